game_ctrl: RTL



---
 rtl/game_pkg.sv | 25 ++
 rtl/game_ctrl_if.sv | 23 ++
 rtl/game_ctrl_hit_detect.sv | 43 ++++
 rtl/game_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game-level blocks (game controller,
// bird physics, pipe scroller).
//   game_state_t  : 2-bit controller state, also shown on state_o
//   SCREEN_W/H    : visible area in pixels
//   DEF_CEIL_Y    : default top boundary row
//   DEF_GROUND_Y  : default bottom boundary row
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_DEAD    = 2'd2,
        ST_RESTART = 2'd3
    } game_state_t;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int DEF_CEIL_Y   = 8;
    localparam int DEF_GROUND_Y = 440;

    function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: control/feedback bundle between the game controller and the
// bird physics block.
//   enable, game_reset, collision, flap : controller -> physics
//   bird_x, bird_y                      : physics -> controller
// master = game controller, slave = bird physics.
interface game_ctrl_if;
    logic        enable;
    logic        game_reset;
    logic        collision;
    logic        flap;
    logic [10:0] bird_x;
    logic [10:0] bird_y;

    modport master (
        output enable, game_reset, collision, flap,
        input  bird_x, bird_y
    );

    modport slave (
        input  enable, game_reset, collision, flap,
        output bird_x, bird_y
    );
endinterface

// File: rtl/game_ctrl_hit_detect.sv
// hit_detect: purely combinational bird-vs-pipe and bird-vs-boundary check.
//   bird_x, bird_y   : bird sprite top-left corner
//   pipe_x           : pipe left edge
//   gap_top, gap_bot : first and last open row of the pipe gap
//   hit              : bird overlaps the pipe body or leaves the play field
// All arithmetic is widened to 12 bits so edge sums never wrap.
module hit_detect
    import game_pkg::*;
#(
    parameter int BIRD_W   = 16,
    parameter int BIRD_H   = 16,
    parameter int PIPE_W   = 40,
    parameter int CEIL_Y   = DEF_CEIL_Y,
    parameter int GROUND_Y = DEF_GROUND_Y
) (
    input  logic [10:0] bird_x,
    input  logic [10:0] bird_y,
    input  logic [10:0] pipe_x,
    input  logic [10:0] gap_top,
    input  logic [10:0] gap_bot,
    output logic        hit
);

    logic [11:0] bx, by, px, gt, gb;
    logic        hx, hy, ceil_hit, ground_hit;

    assign bx = {1'b0, bird_x};
    assign by = {1'b0, bird_y};
    assign px = {1'b0, pipe_x};
    assign gt = {1'b0, gap_top};
    assign gb = {1'b0, gap_bot};

    // Horizontal overlap of the two rectangles.
    assign hx = (px < bx + 12'(BIRD_W)) && (bx < px + 12'(PIPE_W));
    // Bird pokes above the gap or below its last open row.
    assign hy = (by < gt) || (by + 12'(BIRD_H) > gb + 12'd1);

    assign ceil_hit   = by < 12'(CEIL_Y);
    assign ground_hit = by + 12'(BIRD_H) > 12'(GROUND_Y);

    assign hit = (hx && hy) || ceil_hit || ground_hit;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game-level sequencer. Drives the bird physics controls, detects
// collisions, counts score and keeps the high score.
//   clk, reset        : frame clock, synchronous active-high reset
//   btn               : synchronised flap button (level)
//   phys              : physics control/feedback bundle (master side)
//   pipe_x            : pipe left edge
//   gap_top, gap_bot  : pipe gap rows
//   score, high_score : current (saturating) and best score since reset
//   state_o           : current state for display
// Every output comes straight from a register.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for first press; physics disabled
// PLAY    | game running; flap on each press, hit and score evaluated
// DEAD    | bird frozen; restart accepted once the dead timer has expired
// RESTART | single cycle pulsing game_reset, clears score
module game_ctrl
    import game_pkg::*;
#(
    parameter int BIRD_W      = 16,
    parameter int BIRD_H      = 16,
    parameter int PIPE_W      = 40,
    parameter int CEIL_Y      = DEF_CEIL_Y,
    parameter int GROUND_Y    = DEF_GROUND_Y,
    parameter int DEAD_CYCLES = 60
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn,
    game_ctrl_if.master   phys,
    input  logic [10:0]   pipe_x,
    input  logic [10:0]   gap_top,
    input  logic [10:0]   gap_bot,
    output logic [7:0]    score,
    output logic [7:0]    high_score,
    output logic [1:0]    state_o
);

    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);

    game_state_t state_q, state_d;
    logic             btn_q;
    logic             enable_q, enable_d;
    logic             game_reset_q, game_reset_d;
    logic             collision_q, collision_d;
    logic             flap_q, flap_d;
    logic [7:0]       score_q, score_d;
    logic [7:0]       high_score_q, high_score_d;
    logic [CNT_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [11:0]      trail, trail_q, bx;
    logic             btn_edge, hit, score_ev;

    hit_detect #(
        .BIRD_W   (BIRD_W),
        .BIRD_H   (BIRD_H),
        .PIPE_W   (PIPE_W),
        .CEIL_Y   (CEIL_Y),
        .GROUND_Y (GROUND_Y)
    ) u_hit (
        .bird_x  (phys.bird_x),
        .bird_y  (phys.bird_y),
        .pipe_x  (pipe_x),
        .gap_top (gap_top),
        .gap_bot (gap_bot),
        .hit     (hit)
    );

    assign btn_edge = btn & ~btn_q;
    assign bx       = {1'b0, phys.bird_x};
    assign trail    = {1'b0, pipe_x} + 12'(PIPE_W);
    // Trailing edge crosses the bird's left edge moving left. A wrap makes
    // trail jump upward, so it can never satisfy trail < bx after trail_q >= bx.
    assign score_ev = (trail_q >= bx) && (trail < bx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            btn_q        <= 1'b0;
            enable_q     <= 1'b0;
            game_reset_q <= 1'b0;
            collision_q  <= 1'b0;
            flap_q       <= 1'b0;
            score_q      <= 8'd0;
            high_score_q <= 8'd0;
            dead_cnt_q   <= '0;
            trail_q      <= 12'd0;
        end else begin
            state_q      <= state_d;
            btn_q        <= btn;
            enable_q     <= enable_d;
            game_reset_q <= game_reset_d;
            collision_q  <= collision_d;
            flap_q       <= flap_d;
            score_q      <= score_d;
            high_score_q <= high_score_d;
            dead_cnt_q   <= dead_cnt_d;
            trail_q      <= trail;
        end
    end

    // Outputs are computed for the state being entered so that the
    // registered values line up with state_o.
    always_comb begin
        state_d      = state_q;
        enable_d     = 1'b0;
        game_reset_d = 1'b0;
        collision_d  = 1'b0;
        flap_d       = 1'b0;
        score_d      = score_q;
        high_score_d = high_score_q;
        dead_cnt_d   = dead_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (btn_edge) begin
                    state_d  = ST_PLAY;
                    enable_d = 1'b1;
                    flap_d   = 1'b1;
                end
            end
            ST_PLAY: begin
                enable_d = 1'b1;
                if (hit) begin
                    state_d      = ST_DEAD;
                    collision_d  = 1'b1;
                    high_score_d = max_u8(high_score_q, score_q);
                    dead_cnt_d   = '0;
                end else begin
                    flap_d = btn_edge;
                    if (score_ev && score_q != 8'hFF)
                        score_d = score_q + 8'd1;
                end
            end
            ST_DEAD: begin
                enable_d    = 1'b1;
                collision_d = 1'b1;
                if (dead_cnt_q < CNT_W'(DEAD_CYCLES))
                    dead_cnt_d = dead_cnt_q + CNT_W'(1);
                if (btn_edge && dead_cnt_q == CNT_W'(DEAD_CYCLES)) begin
                    state_d      = ST_RESTART;
                    enable_d     = 1'b0;
                    collision_d  = 1'b0;
                    game_reset_d = 1'b1;
                    score_d      = 8'd0;
                end
            end
            ST_RESTART: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign phys.enable     = enable_q;
    assign phys.game_reset = game_reset_q;
    assign phys.collision  = collision_q;
    assign phys.flap       = flap_q;
    assign score           = score_q;
    assign high_score      = high_score_q;
    assign state_o         = state_q;

endmodule
